// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants and FSM state type for the configuration commit arbiter
package cfg_pkg;
  localparam int CFG_W = 5;
  localparam int A_BIT = 4;
  localparam int B_BIT = 3;
  localparam int C_BIT = 2;
  localparam int D_BIT = 1;
  localparam int E_BIT = 0;
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
endpackage

// File: rtl/cfg_valid_check.sv
// cfg_valid_check: combinational evaluator of the five-bit configuration validity rule
module cfg_valid_check
  import cfg_pkg::*;
(
  input  logic [CFG_W-1:0] cfg,
  output logic             valid
);
  logic a, b, c, d, e;
  assign a = cfg[A_BIT];
  assign b = cfg[B_BIT];
  assign c = cfg[C_BIT];
  assign d = cfg[D_BIT];
  assign e = cfg[E_BIT];
  assign valid = (a | b) & (c ^ e) & (a & c) & (~d | e) & (~b | (a & d));
endmodule

// File: rtl/cfg_commit_arbiter.sv
// cfg_commit_arbiter: round-robin arbiter that validates and commits configuration words
module cfg_commit_arbiter
  import cfg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CFG_W-1:0] cfg_in0,
  input  logic [CFG_W-1:0] cfg_in1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             ok,
  output logic             busy,
  output logic [CFG_W-1:0] active_cfg,
  output logic             active_vld,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] rej_cnt
);
  state_t state, nxt;
  logic ptr, own, res, w, valid;
  logic [CFG_W-1:0] cap;
  cfg_valid_check u_chk (.cfg(cap), .valid(valid));
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    w = (req == 2'b11) ? ptr : req[1];
    nxt = state == IDLE ? (|req ? CHECK : IDLE) : state == CHECK ? RESP : IDLE;
    gnt = (state == IDLE && |req) ? (w ? 2'b10 : 2'b01) : 2'b00;
    done = state == RESP ? (own ? 2'b10 : 2'b01) : 2'b00;
    ok = state == RESP && res;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
      own <= 1'b0;
      cap <= '0;
      res <= 1'b0;
      active_cfg <= '0;
      active_vld <= 1'b0;
      acc_cnt <= '0;
      rej_cnt <= '0;
    end else begin
      if (|gnt) begin
        ptr <= ~w;
        own <= w;
        cap <= w ? cfg_in1 : cfg_in0;
      end
      if (state == CHECK) res <= valid;
      if (state == RESP) begin
        if (res) begin
          active_cfg <= cap;
          active_vld <= 1'b1;
          if (~&acc_cnt) acc_cnt <= acc_cnt + CNT_W'(1);
        end else if (~&rej_cnt) rej_cnt <= rej_cnt + CNT_W'(1);
      end
    end
  end
endmodule
